// File: rtl/pipe_wide_incr.sv
// pipe_wide_incr: pipelined wide incrementer, out_data = in_data + zero-extended in_step.
// The carry chain is cut into SEG_W-bit segments, one segment summed per stage, with a
// valid/ready handshake, per-beat overflow flag and a 32-bit delivered-beat counter.
// Optional build macro PIPE_WIDE_INCR_SAT_EN: saturate out_data to all ones on overflow
// (default build wraps modulo 2^WIDTH; out_ovf is the same in both builds).
module pipe_wide_incr #(
  parameter int WIDTH  = 70,
  parameter int SEG_W  = 32,
  parameter int STEP_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STEP_W-1:0] in_step,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_ovf,
  output logic [31:0]       out_count
);

  localparam int NSEG = (WIDTH + SEG_W - 1) / SEG_W;
  // Padded working width so every segment is a full SEG_W slice.
  localparam int PW   = NSEG * SEG_W;
  // Number of real data bits in the top segment.
  localparam int TOPW = WIDTH - (NSEG - 1) * SEG_W;
  localparam logic [PW-1:0] MASK = PW'({{PW{1'b0}}, {WIDTH{1'b1}}});

  // Stage registers: partially summed data, step still to be consumed, carry, valid.
  logic [NSEG-1:0][PW-1:0] r_acc;
  logic [NSEG-1:0][PW-1:0] r_stp;
  logic [NSEG-1:0]         r_cy;
  logic [NSEG-1:0]         r_v;
  logic [31:0]             r_count;

  // Source of each stage: index 0 is the input port, index k is stage k-1.
  logic [NSEG:0][PW-1:0]   w_acc_ext;
  logic [NSEG:0][PW-1:0]   w_stp_ext;
  logic [NSEG:0]           w_cy_ext;
  logic [NSEG:0]           w_v_ext;
  logic [NSEG-1:0][PW-1:0] w_nacc;
  logic [NSEG-1:0]         w_ncy;
  logic [NSEG-1:0]         w_ld;

  assign w_acc_ext = {r_acc, PW'(in_data)};
  assign w_stp_ext = {r_stp, PW'(in_step)};
  assign w_cy_ext  = {r_cy, 1'b0};
  assign w_v_ext   = {r_v, in_valid};

  // Load enables ripple back from out_ready (an empty stage always accepts) and each
  // stage adds its own segment with the carry registered by the stage below.
  always_comb begin
    logic [SEG_W:0] sum;
    logic           ld;
    ld  = out_ready;
    sum = '0;
    for (int k = NSEG - 1; k >= 0; k--) begin
      ld      = ld | ~r_v[k];
      w_ld[k] = ld;
    end
    for (int k = 0; k < NSEG; k++) begin
      sum = {1'b0, w_acc_ext[k][k*SEG_W +: SEG_W]}
          + {1'b0, w_stp_ext[k][k*SEG_W +: SEG_W]}
          + {{SEG_W{1'b0}}, w_cy_ext[k]};
      w_nacc[k] = w_acc_ext[k];
      w_nacc[k][k*SEG_W +: SEG_W] = sum[SEG_W-1:0];
      if (k == NSEG - 1) begin
        // Carry out of bit WIDTH-1 sits at bit TOPW of the top segment sum.
        w_ncy[k] = sum[TOPW];
`ifdef PIPE_WIDE_INCR_SAT_EN
        if (sum[TOPW]) begin
          w_nacc[k] = MASK;
        end else begin
          w_nacc[k] = w_nacc[k] & MASK;
        end
`else
        w_nacc[k] = w_nacc[k] & MASK;
`endif
      end else begin
        w_ncy[k] = sum[SEG_W];
      end
    end
  end

  assign in_ready = reset | w_ld[0];

  // Pipeline stage registers and delivered-beat counter; reset discards all beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_stp   <= '0;
      r_cy    <= '0;
      r_v     <= '0;
      r_count <= 32'd0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (w_ld[k]) begin
          r_v[k]   <= w_v_ext[k];
          r_acc[k] <= w_nacc[k];
          r_stp[k] <= w_stp_ext[k];
          r_cy[k]  <= w_ncy[k];
        end
      end
      if (r_v[NSEG-1] & out_ready) begin
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign out_valid = r_v[NSEG-1];
  assign out_data  = r_acc[NSEG-1][WIDTH-1:0];
  assign out_ovf   = r_cy[NSEG-1];
  assign out_count = r_count;

endmodule

// File: tb/tb_pipe_wide_incr.sv
// Directed self-checking bench for pipe_wide_incr (WIDTH=70, SEG_W=32, STEP_W=32, NSEG=3).
module tb_pipe_wide_incr;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [69:0] in_data;
  logic [31:0] in_step;
  logic        out_valid;
  logic        out_ready;
  logic [69:0] out_data;
  logic        out_ovf;
  logic [31:0] out_count;

  int total;
  int bad;

  pipe_wide_incr #(.WIDTH(70), .SEG_W(32), .STEP_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_step   (in_step),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [69:0] ones;
    logic [69:0] exp_ovf_data;
    int acc;
    int got;
    total = 0;
    bad   = 0;
    ones  = {70{1'b1}};
`ifdef PIPE_WIDE_INCR_SAT_EN
    exp_ovf_data = ones;
`else
    exp_ovf_data = 70'h0;
`endif

    // Reset state
    reset = 1'b1; in_valid = 1'b0; in_data = 70'h0; in_step = 32'h0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 70'(in_ready), 70'h1);
    reset = 1'b0;
    tick();
    chk("rst_valid", 70'(out_valid), 70'h0);
    chk("rst_data", out_data, 70'h0);
    chk("rst_ovf", 70'(out_ovf), 70'h0);
    chk("rst_count", 70'(out_count), 70'h0);

    // 1: carry across a segment boundary, exact latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 70'h0_FFFFFFFF; in_step = 32'd1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t1_not_early", 70'(out_valid), 70'h0);
    tick();
    chk("t1_valid", 70'(out_valid), 70'h1);
    chk("t1_data", out_data, 70'h1_00000000);
    chk("t1_ovf", 70'(out_ovf), 70'h0);
    tick();
    chk("t1_drained", 70'(out_valid), 70'h0);
    chk("t1_count", 70'(out_count), 70'd1);

    // 2: overflow out of bit 69
    in_valid = 1'b1; in_data = ones; in_step = 32'd1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t2_valid", 70'(out_valid), 70'h1);
    chk("t2_data", out_data, exp_ovf_data);
    chk("t2_ovf", 70'(out_ovf), 70'h1);
    tick();
    chk("t2_count", 70'(out_count), 70'd2);

    // 3: 10 back-to-back beats, data = i + 5
    for (int c = 0; c < 13; c++) begin
      in_valid = (c < 10);
      in_data  = 70'(c);
      in_step  = 32'd5;
      tick();
      if (c >= 2 && c < 12) begin
        chk("t3_valid", 70'(out_valid), 70'h1);
        chk("t3_data", out_data, 70'(c - 2 + 5));
      end else if (c == 12) begin
        chk("t3_end_valid", 70'(out_valid), 70'h0);
      end
    end
    in_valid = 1'b0;
    chk("t3_count", 70'(out_count), 70'd12);

    // 4: backpressure, 5 beats offered with out_ready low
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 5);
      in_data  = 70'(100 + acc);
      in_step  = 32'd1;
      #1;
      if (in_valid && in_ready) acc++;
      tick();
    end
    #1;
    chk("t4_accepted", 70'(acc), 70'd3);
    chk("t4_in_ready", 70'(in_ready), 70'h0);
    chk("t4_hold_valid", 70'(out_valid), 70'h1);
    chk("t4_hold_data", out_data, 70'd101);
    tick();
    chk("t4_stable_data", out_data, 70'd101);
    chk("t4_stable_ovf", 70'(out_ovf), 70'h0);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (got == 5) break;
      in_valid = (acc < 5);
      in_data  = 70'(100 + acc);
      #1;
      if (out_valid) begin
        chk("t4_order", out_data, 70'(101 + got));
        got++;
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("t4_all_delivered", 70'(got), 70'd5);
    chk("t4_count", 70'(out_count), 70'd17);

    // 5: reset with two beats in flight
    in_valid = 1'b1; in_data = 70'd7; in_step = 32'd1;
    tick();
    in_data = 70'd8;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_valid", 70'(out_valid), 70'h0);
    chk("t5_count", 70'(out_count), 70'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_no_stale", 70'(out_valid), 70'h0);
    end

    // 6: bubbles, in_valid toggling
    for (int c = 0; c < 9; c++) begin
      in_valid = (c % 2 == 0) && (c < 6);
      in_data  = 70'(20 * (c / 2 + 1));
      in_step  = 32'd3;
      tick();
      if (c == 2 || c == 4 || c == 6) begin
        chk("t6_valid", 70'(out_valid), 70'h1);
        chk("t6_data", out_data, 70'(20 * ((c - 2) / 2 + 1) + 3));
      end else begin
        chk("t6_bubble", 70'(out_valid), 70'h0);
      end
    end
    in_valid = 1'b0;
    chk("t6_count", 70'(out_count), 70'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
